// File: rtl/can_rx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : can_rx_scheduler
// Desc     : Shares the 8-bit CAN access engine between CPU pass-through
//            accesses and a hardware RX drain into a local byte FIFO.
// Options  : `define CAN_RX_IRQ_EN drives irq_o from FIFO non-empty.
// Revision : 1.0 - initial release
// ============================================================================
module can_rx_scheduler #(
  parameter int FIFO_AW   = 6,
  parameter int LOCAL_BIT = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr_32b_i,
  input  logic        wren_i,
  input  logic        rden_i,
  input  logic [31:0] din_32b_i,
  output logic [31:0] dout_32b_o,
  output logic        dout_32b_valid_o,
  output logic [31:0] eng_addr_32b_o,
  output logic        eng_wren_o,
  output logic        eng_rden_o,
  output logic [31:0] eng_din_32b_o,
  input  logic [31:0] eng_dout_32b_i,
  input  logic        eng_dout_32b_valid_i,
  input  logic        can_int_n_i,
  output logic        irq_o
);

  localparam int c_CW = FIFO_AW + 1;
  localparam logic [FIFO_AW:0] c_DEPTH = {1'b1, {FIFO_AW{1'b0}}};

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_CPU  = 3'd1;
  localparam logic [2:0] c_IR   = 3'd2;
  localparam logic [2:0] c_FI   = 3'd3;
  localparam logic [2:0] c_BYTE = 3'd4;
  localparam logic [2:0] c_REL  = 3'd5;

  localparam logic [7:0] c_IDX_CMR = 8'd1;
  localparam logic [7:0] c_IDX_IR  = 8'd3;
  localparam logic [7:0] c_IDX_FI  = 8'd16;

  logic             r_int_meta, r_int_sync;
  logic [2:0]       r_state, w_state_nxt, r_resume, w_drain_nxt;
  logic             r_issued;
  logic             r_pend, r_pend_wr;
  logic [7:0]       r_pend_idx, r_pend_byte;
  logic [3:0]       r_len, r_byte_idx;
  logic [7:0]       r_drop;
  logic [7:0]       r_mem [c_DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_CW-1:0]  r_count, w_count_nxt, w_free;
  logic [31:0]      r_dout;
  logic             r_dout_valid;

  logic             w_eng_done, w_issue, w_eng_wr, w_fits, w_push, w_pop, w_flush;
  logic             w_req, w_local, w_empty;
  logic [7:0]       w_eng_byte, w_eng_idx, w_eng_wdata, w_req_idx;
  logic [3:0]       w_dlc, w_len;
  logic [31:0]      w_local_rdata;
  logic             w_unused;

  assign w_unused = ^{addr_32b_i[31:10], addr_32b_i[1:0], din_32b_i[31:8],
                      eng_dout_32b_i[31:8]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_int_meta <= 1'b1;
      r_int_sync <= 1'b1;
    end else begin
      r_int_meta <= can_int_n_i;
      r_int_sync <= r_int_meta;
    end
  end

  assign w_eng_done = r_issued & eng_dout_32b_valid_i;
  assign w_eng_byte = eng_dout_32b_i[7:0];
  assign w_dlc      = (eng_dout_32b_i[3:0] > 4'd8) ? 4'd8 : eng_dout_32b_i[3:0];
  assign w_len      = 4'd1 + (eng_dout_32b_i[7] ? 4'd4 : 4'd2) + w_dlc;
  assign w_free     = c_DEPTH - r_count;
  assign w_fits     = (w_free >= c_CW'(w_len));
  assign w_empty    = (r_count == '0);

  // FSM state register; r_issued marks that the current state's single engine pulse went out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_IDLE;
      r_issued <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_eng_done)
        r_issued <= 1'b0;
      else if (r_state != c_IDLE)
        r_issued <= 1'b1;
    end
  end

  always_comb begin
    w_drain_nxt = c_IDLE;
    case (r_state)
      c_IR:    w_drain_nxt = w_eng_byte[0] ? c_FI : c_IDLE;
      c_FI:    w_drain_nxt = w_fits ? c_BYTE : c_REL;
      c_BYTE:  w_drain_nxt = (r_byte_idx == r_len - 4'd1) ? c_REL : c_BYTE;
      c_REL:   w_drain_nxt = c_IR;
      default: w_drain_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (r_pend)
          w_state_nxt = c_CPU;
        else if (!r_int_sync)
          w_state_nxt = c_IR;
      end
      c_CPU: begin
        if (w_eng_done)
          w_state_nxt = r_resume;
      end
      c_IR, c_FI, c_BYTE, c_REL: begin
        if (w_eng_done)
          w_state_nxt = r_pend ? c_CPU : w_drain_nxt;
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    w_eng_idx   = 8'd0;
    w_eng_wr    = 1'b0;
    w_eng_wdata = 8'd0;
    case (r_state)
      c_CPU: begin
        w_eng_idx   = r_pend_idx;
        w_eng_wr    = r_pend_wr;
        w_eng_wdata = r_pend_wr ? r_pend_byte : 8'd0;
      end
      c_IR:   w_eng_idx = c_IDX_IR;
      c_FI:   w_eng_idx = c_IDX_FI;
      c_BYTE: w_eng_idx = c_IDX_FI + {4'd0, r_byte_idx};
      c_REL: begin
        w_eng_idx   = c_IDX_CMR;
        w_eng_wr    = 1'b1;
        w_eng_wdata = 8'h04;
      end
      default: w_eng_idx = 8'd0;
    endcase
  end

  assign w_issue        = (r_state != c_IDLE) && !r_issued;
  assign eng_wren_o     = w_issue & w_eng_wr;
  assign eng_rden_o     = w_issue & ~w_eng_wr;
  assign eng_addr_32b_o = {22'd0, w_eng_idx, 2'b00};
  assign eng_din_32b_o  = {24'd0, w_eng_wdata};

  // Drain bookkeeping: resume point survives a CPU interjection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resume   <= c_IDLE;
      r_len      <= 4'd0;
      r_byte_idx <= 4'd0;
      r_drop     <= 8'd0;
    end else begin
      if (w_state_nxt == c_CPU && r_state != c_CPU)
        r_resume <= (r_state == c_IDLE) ? c_IDLE : w_drain_nxt;
      if (w_eng_done && r_state == c_FI) begin
        r_len      <= w_len;
        r_byte_idx <= 4'd1;
        if (!w_fits && r_drop != 8'hFF)
          r_drop <= r_drop + 8'd1;
      end
      if (w_eng_done && r_state == c_BYTE)
        r_byte_idx <= r_byte_idx + 4'd1;
    end
  end

  assign w_req     = (rden_i | wren_i) & ~r_pend;
  assign w_local   = addr_32b_i[LOCAL_BIT];
  assign w_req_idx = addr_32b_i[9:2];
  assign w_pop     = w_req & w_local & ~wren_i & (w_req_idx == 8'd0) & ~w_empty;
  assign w_flush   = w_req & w_local & wren_i & (w_req_idx == 8'd2) & din_32b_i[0];
  assign w_push    = w_eng_done & (((r_state == c_FI) & w_fits) | (r_state == c_BYTE));

  always_comb begin
    w_local_rdata = 32'd0;
    if (!wren_i) begin
      if (w_req_idx == 8'd0)
        w_local_rdata = {23'd0, w_empty, w_empty ? 8'h00 : r_mem[r_rd_ptr]};
      else if (w_req_idx == 8'd1)
        w_local_rdata = {16'd0, r_drop, 1'b0, 7'(r_count)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend       <= 1'b0;
      r_pend_wr    <= 1'b0;
      r_pend_idx   <= 8'd0;
      r_pend_byte  <= 8'd0;
      r_dout       <= 32'd0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= 1'b0;
      if (w_req && !w_local) begin
        r_pend      <= 1'b1;
        r_pend_wr   <= wren_i;
        r_pend_idx  <= w_req_idx;
        r_pend_byte <= din_32b_i[7:0];
      end
      if (w_req && w_local) begin
        r_dout       <= w_local_rdata;
        r_dout_valid <= 1'b1;
      end
      if (r_state == c_CPU && w_eng_done) begin
        r_pend       <= 1'b0;
        r_dout       <= {24'd0, w_eng_byte};
        r_dout_valid <= 1'b1;
      end
    end
  end

  assign dout_32b_o       = r_dout;
  assign dout_32b_valid_o = r_dout_valid;

  assign w_count_nxt = w_flush ? '0 : (r_count + c_CW'(w_push) - c_CW'(w_pop));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= w_eng_byte;
  end

`ifdef CAN_RX_IRQ_EN
  logic r_irq;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_irq <= 1'b0;
    else
      r_irq <= (w_count_nxt != '0);
  end
  assign irq_o = r_irq;
`else
  assign irq_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_can_rx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_can_rx_scheduler
// Desc     : Scoreboard bench with a reactive CAN engine model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_can_rx_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] din = 32'd0;
  logic        wren = 1'b0;
  logic        rden = 1'b0;
  logic [31:0] dout;
  logic        dout_valid;
  logic [31:0] eng_addr, eng_din;
  logic        eng_wren, eng_rden;
  logic [31:0] eng_dout = 32'd0;
  logic        eng_valid = 1'b0;
  logic        can_int_n;
  logic        irq;

  always #5 clk = ~clk;

  can_rx_scheduler #(.FIFO_AW(6), .LOCAL_BIT(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .addr_32b_i(addr), .wren_i(wren), .rden_i(rden), .din_32b_i(din),
    .dout_32b_o(dout), .dout_32b_valid_o(dout_valid),
    .eng_addr_32b_o(eng_addr), .eng_wren_o(eng_wren), .eng_rden_o(eng_rden),
    .eng_din_32b_o(eng_din), .eng_dout_32b_i(eng_dout),
    .eng_dout_32b_valid_i(eng_valid), .can_int_n_i(can_int_n), .irq_o(irq)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int resp_cnt = 0;

  logic [31:0] exp_cpu_q[$];
  logic [40:0] exp_eng_q[$];
  logic [7:0]  fifo_model[$];

  logic [7:0]  eng_mem [256];
  logic [7:0]  fr_mem [16][13];
  int          fr_head = 0;
  int          fr_tail = 0;
  int          fr_serial = 0;
  int          eng_cnt = 0;
  logic [7:0]  eng_rd = 8'd0;
  logic [7:0]  eng_idx;
  logic [40:0] eng_got;
  logic [31:0] eng_last_addr = 32'd0;

  assign can_int_n = (fr_head == fr_tail);

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [40:0] rd_txn(input logic [7:0] idx);
    return {1'b0, 22'd0, idx, 2'b00, 8'h00};
  endfunction

  // Engine model: answers every request three cycles later; IR reports RI while frames are queued
  always @(posedge clk) begin
    eng_valid <= 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) begin
        eng_valid <= 1'b1;
        eng_dout  <= {24'd0, eng_rd};
      end
    end
    if (rst_n && (eng_wren || eng_rden)) begin
      eng_got = {eng_wren, eng_addr, eng_wren ? eng_din[7:0] : 8'h00};
      if (exp_eng_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL eng_txn: got unexpected access 0x%011h, none required", eng_got);
      end else begin
        check("eng_txn", {23'd0, eng_got}, {23'd0, exp_eng_q.pop_front()});
      end
      eng_last_addr <= eng_addr;
      eng_cnt <= 3;
      eng_idx = eng_addr[9:2];
      if (eng_wren) begin
        eng_mem[eng_idx] <= eng_din[7:0];
        eng_rd <= 8'h00;
        if (eng_idx == 8'd1 && eng_din[7:0] == 8'h04 && fr_head != fr_tail)
          fr_head <= fr_head + 1;
      end else if (eng_idx == 8'd3) begin
        eng_rd <= (fr_head != fr_tail) ? 8'h01 : 8'h5A;
      end else if (eng_idx >= 8'd16 && eng_idx < 8'd29 && fr_head != fr_tail) begin
        eng_rd <= fr_mem[fr_head % 16][eng_idx - 8'd16];
      end else begin
        eng_rd <= eng_mem[eng_idx];
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && dout_valid) begin
      resp_cnt++;
      if (exp_cpu_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL cpu_resp: got unexpected valid with 0x%08h, none required", dout);
      end else begin
        check("cpu_resp", {32'd0, dout}, {32'd0, exp_cpu_q.pop_front()});
      end
    end
  end

  task automatic cpu_access(input logic wr, input logic [31:0] a, input logic [7:0] d,
                            input logic [31:0] exp, input bit push_eng);
    int start;
    exp_cpu_q.push_back(exp);
    if (push_eng)
      exp_eng_q.push_back({wr, 22'd0, a[9:2], 2'b00, wr ? d : 8'h00});
    start = resp_cnt;
    @(negedge clk);
    addr = a;
    din  = {24'd0, d};
    wren = wr;
    rden = !wr;
    @(negedge clk);
    wren = 1'b0;
    rden = 1'b0;
    for (int i = 0; i < 100 && resp_cnt == start; i++) begin
      @(negedge clk);
      #1;
    end
    if (resp_cnt == start) begin
      n_cmp++;
      n_fail++;
      $display("FAIL cpu_timeout: got no valid for addr 0x%08h, required one", a);
      void'(exp_cpu_q.pop_back());
    end
  endtask

  task automatic add_frame(input logic [7:0] fi, input int len, input bit accept, input int cpu_after);
    int slot;
    slot = fr_tail % 16;
    fr_serial++;
    fr_mem[slot][0] = fi;
    for (int k = 1; k < 13; k++)
      fr_mem[slot][k] = 8'(fr_serial * 16 + k);
    exp_eng_q.push_back(rd_txn(8'd3));
    exp_eng_q.push_back(rd_txn(8'd16));
    if (accept) begin
      fifo_model.push_back(fi);
      for (int k = 1; k < len; k++) begin
        exp_eng_q.push_back(rd_txn(8'(16 + k)));
        fifo_model.push_back(fr_mem[slot][k]);
        if (k == cpu_after)
          exp_eng_q.push_back({1'b1, 32'h0000_0024, 8'h33});
      end
    end
    exp_eng_q.push_back({1'b1, 32'h0000_0004, 8'h04});
    fr_tail++;
  endtask

  task automatic wait_drain();
    int i;
    for (i = 0; i < 3000 && exp_eng_q.size() != 0; i++)
      @(negedge clk);
    if (exp_eng_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d engine accesses outstanding, required 0", exp_eng_q.size());
      exp_eng_q.delete();
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic pop_all();
    logic [7:0] b;
    while (fifo_model.size() > 0) begin
      b = fifo_model.pop_front();
      cpu_access(1'b0, 32'h0000_1000, 8'h00, {24'd0, b}, 1'b0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_dout", {32'd0, dout}, 64'd0);
    check("rst_valid", {63'd0, dout_valid}, 64'd0);
    check("rst_eng_wren", {63'd0, eng_wren}, 64'd0);
    check("rst_eng_rden", {63'd0, eng_rden}, 64'd0);
    check("rst_eng_addr", {32'd0, eng_addr}, 64'd0);
    check("rst_eng_din", {32'd0, eng_din}, 64'd0);
    check("rst_irq", {63'd0, irq}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    cpu_access(1'b0, 32'h0000_1004, 8'h00, 32'h0000_0000, 1'b0);
    cpu_access(1'b0, 32'h0000_1000, 8'h00, 32'h0000_0100, 1'b0);

    cpu_access(1'b0, 32'h0000_000C, 8'h00, 32'h0000_005A, 1'b1);
    cpu_access(1'b1, 32'h0000_0020, 8'h77, 32'h0000_0000, 1'b1);
    cpu_access(1'b0, 32'h0000_0020, 8'h00, 32'h0000_0077, 1'b1);
    cpu_access(1'b1, 32'h0000_100C, 8'h01, 32'h0000_0000, 1'b0);

    // Standard frame, DLC 3: six bytes from regs 16..21
    add_frame(8'h03, 6, 1'b1, -1);
    exp_eng_q.push_back(rd_txn(8'd3));
    wait_drain();
    cpu_access(1'b0, 32'h0000_1004, 8'h00, 32'h0000_0006, 1'b0);
`ifdef CAN_RX_IRQ_EN
    check("irq_set", {63'd0, irq}, 64'd1);
`else
    check("irq_off", {63'd0, irq}, 64'd0);
`endif
    pop_all();
    @(negedge clk);
    check("irq_clear", {63'd0, irq}, 64'd0);
    cpu_access(1'b0, 32'h0000_1000, 8'h00, 32'h0000_0100, 1'b0);

    // Four extended DLC15 frames (13 each) plus one of 8 fill 60 bytes; an 11-byte frame is dropped
    add_frame(8'h8F, 13, 1'b1, -1);
    add_frame(8'h8F, 13, 1'b1, -1);
    add_frame(8'h8F, 13, 1'b1, -1);
    add_frame(8'h8F, 13, 1'b1, -1);
    add_frame(8'h05, 8, 1'b1, -1);
    add_frame(8'h08, 11, 1'b0, -1);
    exp_eng_q.push_back(rd_txn(8'd3));
    wait_drain();
    cpu_access(1'b0, 32'h0000_1004, 8'h00, 32'h0000_013C, 1'b0);
    pop_all();
    cpu_access(1'b0, 32'h0000_1004, 8'h00, 32'h0000_0100, 1'b0);

    // CPU write lands while byte 3 (reg 19) is in flight
    add_frame(8'h08, 11, 1'b1, 3);
    exp_eng_q.push_back(rd_txn(8'd3));
    begin
      int i;
      for (i = 0; i < 500 && eng_last_addr != 32'h0000_004C; i++)
        @(negedge clk);
      if (eng_last_addr != 32'h0000_004C) begin
        n_cmp++;
        n_fail++;
        $display("FAIL byte3_wait: got last engine addr 0x%08h, required 0x0000004c", eng_last_addr);
      end
    end
    cpu_access(1'b1, 32'h0000_0024, 8'h33, 32'h0000_0000, 1'b0);
    wait_drain();
    cpu_access(1'b0, 32'h0000_1004, 8'h00, 32'h0000_010B, 1'b0);
    pop_all();

    // Flush discards a stored frame
    add_frame(8'h01, 4, 1'b1, -1);
    exp_eng_q.push_back(rd_txn(8'd3));
    wait_drain();
    cpu_access(1'b0, 32'h0000_1004, 8'h00, 32'h0000_0104, 1'b0);
    cpu_access(1'b1, 32'h0000_1008, 8'h01, 32'h0000_0000, 1'b0);
    fifo_model.delete();
    cpu_access(1'b0, 32'h0000_1004, 8'h00, 32'h0000_0100, 1'b0);
    cpu_access(1'b0, 32'h0000_1000, 8'h00, 32'h0000_0100, 1'b0);
    @(negedge clk);
    check("irq_after_flush", {63'd0, irq}, 64'd0);

    repeat (5) @(negedge clk);
    check("cpu_q_drained", 64'(exp_cpu_q.size()), 64'd0);
    check("eng_q_drained", 64'(exp_eng_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
